dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder serving the pipeline MEM stage's MemRead/MemWrite requests with LATENCY wait cycles.
// - Holds `stall` high until each access completes; the hazard logic freezes the PC and IF/ID, ID/EX and EX/MEM for that time.
// - Replaces the zero-wait memory model; ReadData feeds MEM/WB unchanged.
// PARAMETERS
// - DEPTH    1024  words of storage (power of 2); index = Address[ADDR_W+1:2], ADDR_W = log2(DEPTH)
// - LATENCY  2     wait cycles inserted per access (0..15)
// PORTS
// - clk        in   1   rising-edge clock, single clock domain
// - rst        in   1   synchronous, active-high reset
// - MemRead    in   1   read request from EX/MEM register
// - MemWrite   in   1   write request from EX/MEM register
// - Address    in   32  byte address (ALU result)
// - writeData  in   32  store data
// - ReadData   out  32  load data, valid while rsp_valid=1
// - stall      out  1   freeze upstream pipeline registers
// - rsp_valid  out  1   one-cycle pulse: access completes this cycle
// - busy       out  1   state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, ReadData=0, rsp_valid=0, busy=0, cnt=0; stall=0 unless a request is present. Array contents are NOT cleared.
// - req = MemRead | MemWrite. stall = (state==IDLE & req) | (state==WAIT). stall is combinational.
// - IDLE: on req, capture op, address index and writeData.
//   - LATENCY>0: cnt<=LATENCY-1, go WAIT.
//   - LATENCY==0: go RESP.
// - WAIT: inputs ignored. If cnt==0, perform the access and go RESP; else cnt<=cnt-1.
// - Access: write commits array[idx]<=wdata and sets ReadData<=0. Read sets ReadData<=array[idx].
// - RESP: rsp_valid=1, stall=0, so the pipeline advances at the end of this cycle. Always return to IDLE next cycle.
//   - In RESP a new req is ignored until IDLE, so no double trigger on the completed instruction.
// - Latency: request first seen at cycle t; rsp_valid at t+LATENCY+1; the next request is accepted at t+LATENCY+2.
// - Conflicts and boundaries:
//   - MemRead & MemWrite both high: treated as a write; ReadData=0.
//   - Address beyond DEPTH words wraps modulo DEPTH. Address[1:0] is ignored unless the option below is enabled.
//   - Read-after-write to the same word on back-to-back requests returns the new data.
// - Reset mid-access: state returns to IDLE, a pending write is dropped (not committed), rsp_valid=0.
// - No request in IDLE: outputs hold, ReadData keeps its last value.
// CONFIGURATION
// - DMEM_ALIGN_CHECK_EN defined:
//   - Adds output `misalign` (1 bit), a registered pulse in RESP when the captured Address[1:0]!=0.
//   - A misaligned write is suppressed (array unchanged); a misaligned read returns 32'hDEADBEEF.
// - Not defined: no `misalign` port; Address[1:0] is ignored; all accesses proceed.
// STRUCTURE
// - Package dmem_pkg: state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2; CNT_W=4; MISALIGN_DATA=32'hDEADBEEF.
// - Sub-module dmem_array: DEPTH x 32 single-port RAM, synchronous write, combinational read.
//   - Instantiated once; the FSM, counter and capture registers stay in dmem_responder.
// TESTING
// - Reset with no req -> stall=0, busy=0, rsp_valid=0, ReadData=0.
// - LATENCY=2: write 32'h1234_5678 @0x10 at cycle t.
//   - Expect stall=1 for t..t+2, rsp_valid at t+3, stall=0 at t+3.
//   - Then a read @0x10 -> ReadData=32'h1234_5678 with rsp_valid.
// - LATENCY=0: back-to-back read, write, read on the same word -> each takes 2 cycles; the second read returns the written value.
// - MemRead=MemWrite=1, Address=0x20, writeData=7 -> array[8]=7, ReadData=0.
//   - Address=DEPTH*4+0x20 reads back 7 (wrap).
// - rst asserted during WAIT of a write of 32'hAAAA @0x40 -> IDLE next cycle; a later read @0x40 returns the prior value.
// - DMEM_ALIGN_CHECK_EN: read @0x41 -> misalign=1, ReadData=32'hDEADBEEF; write @0x42 leaves the array unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM state encoding,
// wait-counter width and the data word returned on a misaligned read.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    localparam logic [31:0] MISALIGN_DATA = 32'hDEAD_BEEF;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 single-port storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Commit a write at the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. Each MemRead/MemWrite request is
// held off for LATENCY wait cycles while `stall` freezes the upstream
// pipeline, then completes with a one-cycle rsp_valid pulse.
// Optional feature: define DMEM_ALIGN_CHECK_EN to add the `misalign` output,
// suppress misaligned writes and return MISALIGN_DATA on misaligned reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] writeData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        rsp_valid,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LAT_M1 = (LATENCY > 0) ? (LATENCY - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = LAT_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              req_s;
    logic              acc_fire_s;
    logic              acc_wr_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic [31:0]       acc_wdata_s;
    logic              acc_mis_s;
    logic              mem_we_s;
    logic [31:0]       mem_rdata_s;
    logic [31:0]       rdata_d;

    // Upper address bits wrap and are intentionally dropped.
    logic unused_addr_s;
    assign unused_addr_s = ^{Address[31:ADDR_W+2], Address[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;
    logic [1:0] acc_lo_s;
    logic       misalign_q;
`endif

    assign req_s = MemRead | MemWrite;

    // Next-state, counter and access-source selection. With LATENCY==0 the
    // access is taken directly from the live inputs on the IDLE edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_fire_s  = 1'b0;
        acc_wr_s    = wr_q;
        acc_idx_s   = idx_q;
        acc_wdata_s = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        acc_lo_s    = lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (LATENCY == 0) begin
                        state_d     = ST_RESP;
                        acc_fire_s  = 1'b1;
                        acc_wr_s    = MemWrite;
                        acc_idx_s   = Address[ADDR_W+1:2];
                        acc_wdata_s = writeData;
`ifdef DMEM_ALIGN_CHECK_EN
                        acc_lo_s    = Address[1:0];
`endif
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    acc_fire_s = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Alignment qualification and the data that ReadData loads on completion.
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        acc_mis_s = is_misaligned(acc_lo_s);
`else
        acc_mis_s = 1'b0;
`endif
        if (acc_wr_s) begin
            rdata_d = 32'h0000_0000;
        end else if (acc_mis_s) begin
            rdata_d = MISALIGN_DATA;
        end else begin
            rdata_d = mem_rdata_s;
        end
    end

    // A write reaching its access edge while reset is asserted is dropped.
    assign mem_we_s = acc_fire_s & acc_wr_s & ~acc_mis_s & ~rst;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (acc_idx_s),
        .wdata_i (acc_wdata_s),
        .rdata_o (mem_rdata_s)
    );

    // FSM, counter, request capture and response-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            wr_q    <= 1'b0;
            idx_q   <= {ADDR_W{1'b0}};
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && req_s) begin
                wr_q    <= MemWrite;
                idx_q   <= Address[ADDR_W+1:2];
                wdata_q <= writeData;
            end
            if (acc_fire_s) begin
                rdata_q <= rdata_d;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Captured byte offset and the misalign pulse that lines up with RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q       <= 2'b00;
            misalign_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && req_s) begin
                lo_q <= Address[1:0];
            end
            misalign_q <= acc_fire_s & acc_mis_s;
        end
    end

    assign misalign = misalign_q;
`endif

    assign ReadData  = rdata_q;
    assign stall     = ((state_q == ST_IDLE) & req_s) | (state_q == ST_WAIT);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 (d=0) and one with
// LATENCY=0 (d=1), driven by directed steps followed by random accesses that
// are checked against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic        l2_rd, l2_wr, l2_stall, l2_valid, l2_busy;
    logic [31:0] l2_addr, l2_wdata, l2_rdata;
    logic        l0_rd, l0_wr, l0_stall, l0_valid, l0_busy;
    logic [31:0] l0_addr, l0_wdata, l0_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        l2_mis, l0_mis;
`endif

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .MemRead(l2_rd), .MemWrite(l2_wr),
        .Address(l2_addr), .writeData(l2_wdata), .ReadData(l2_rdata),
        .stall(l2_stall), .rsp_valid(l2_valid),
`ifdef DMEM_ALIGN_CHECK_EN
        .misalign(l2_mis),
`endif
        .busy(l2_busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .MemRead(l0_rd), .MemWrite(l0_wr),
        .Address(l0_addr), .writeData(l0_wdata), .ReadData(l0_rdata),
        .stall(l0_stall), .rsp_valid(l0_valid),
`ifdef DMEM_ALIGN_CHECK_EN
        .misalign(l0_mis),
`endif
        .busy(l0_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one word array per instance plus bookkeeping.
    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] last_rd [2];
    int unsigned known_q0[$];
    int unsigned known_q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_rdata(input int d);
        return (d == 0) ? l2_rdata : l0_rdata;
    endfunction
    function automatic logic o_stall(input int d);
        return (d == 0) ? l2_stall : l0_stall;
    endfunction
    function automatic logic o_valid(input int d);
        return (d == 0) ? l2_valid : l0_valid;
    endfunction
    function automatic logic o_busy(input int d);
        return (d == 0) ? l2_busy : l0_busy;
    endfunction
`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic o_mis(input int d);
        return (d == 0) ? l2_mis : l0_mis;
    endfunction
`endif

    task automatic drive(input int d, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            l2_rd = rd; l2_wr = wr; l2_addr = a; l2_wdata = w;
        end else begin
            l0_rd = rd; l0_wr = wr; l0_addr = a; l0_wdata = w;
        end
    endtask

    // Called at a falling edge; presents a request held until its response
    // cycle, checks every cycle of it and returns at the next falling edge.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] w);
        int          lat;
        int unsigned idx;
        bit          mis;
        logic [31:0] exp;
        lat = (d == 0) ? 2 : 0;
        idx = (a / 4) % DEPTH;
        mis = ALIGN_EN && ((a % 4) != 0);
        drive(d, rd, wr, a, w);
        #1;
        for (int k = 0; k <= lat; k++) begin
            check("stall_wait", {31'd0, o_stall(d)}, 32'd1);
            check("valid_wait", {31'd0, o_valid(d)}, 32'd0);
            check("busy_wait", {31'd0, o_busy(d)}, (k > 0) ? 32'd1 : 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
            check("mis_wait", {31'd0, o_mis(d)}, 32'd0);
`endif
            @(negedge clk);
        end
        if (wr) begin
            exp = 32'd0;
            if (!mis) begin
                mem_m[d][idx] = w;
                if (d == 0) known_q0.push_back(idx);
                else        known_q1.push_back(idx);
            end
        end else if (mis) begin
            exp = 32'hDEAD_BEEF;
        end else begin
            exp = mem_m[d][idx];
        end
        check("valid_resp", {31'd0, o_valid(d)}, 32'd1);
        check("stall_resp", {31'd0, o_stall(d)}, 32'd0);
        check("busy_resp", {31'd0, o_busy(d)}, 32'd1);
        check("rdata_resp", o_rdata(d), exp);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_resp", {31'd0, o_mis(d)}, {31'd0, mis});
`endif
        last_rd[d] = exp;
        @(negedge clk);
    endtask

    // One cycle without a request: nothing moves, ReadData holds.
    task automatic idle_cycle(input int d);
        drive(d, 1'b0, 1'b0, $urandom, $urandom);
        #1;
        check("stall_idle", {31'd0, o_stall(d)}, 32'd0);
        check("busy_idle", {31'd0, o_busy(d)}, 32'd0);
        check("valid_idle", {31'd0, o_valid(d)}, 32'd0);
        check("rdata_hold", o_rdata(d), last_rd[d]);
        @(negedge clk);
    endtask

    initial begin
        int          d;
        int          op;
        int unsigned idx;
        logic [31:0] a;
        bit          has_known;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (3) @(negedge clk);

        // stall reflects a present request even while in reset
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        #1;
        check("stall_in_reset", {31'd0, l2_stall}, 32'd1);
        drive(0, 1'b0, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_stall", {31'd0, o_stall(i)}, 32'd0);
            check("rst_busy", {31'd0, o_busy(i)}, 32'd0);
            check("rst_valid", {31'd0, o_valid(i)}, 32'd0);
            check("rst_rdata", o_rdata(i), 32'd0);
        end
        @(negedge clk);

        // LATENCY=2 write then read at 0x10
        access(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0);
        idle_cycle(0);

        // LATENCY=0 back-to-back read, write, read of one word
        access(1, 1'b0, 1'b1, 32'h80, 32'hCAFE_0001);
        access(1, 1'b1, 1'b0, 32'h80, 32'd0);
        access(1, 1'b0, 1'b1, 32'h80, 32'h0BAD_F00D);
        access(1, 1'b1, 1'b0, 32'h80, 32'd0);
        idle_cycle(1);

        // Both strobes high is a write; wrapped address reads it back
        access(0, 1'b1, 1'b1, 32'h20, 32'd7);
        access(0, 1'b1, 1'b0, DEPTH * 4 + 32'h20, 32'd0);
        idle_cycle(0);

        // Reset on the would-be commit cycle of a write drops it
        access(0, 1'b0, 1'b1, 32'h40, 32'h1111_2222);
        drive(0, 1'b0, 1'b1, 32'h40, 32'h0000_AAAA);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, l2_busy}, 32'd0);
        check("abort_valid", {31'd0, l2_valid}, 32'd0);
        check("abort_rdata", l2_rdata, 32'd0);
        check("abort_rdata_l0", l0_rdata, 32'd0);
        rst = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        idle_cycle(0);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0);
        idle_cycle(0);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned read returns the marker; misaligned write is dropped
        access(0, 1'b1, 1'b0, 32'h41, 32'd0);
        access(0, 1'b0, 1'b1, 32'h42, 32'h5555_5555);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0);
        idle_cycle(0);
`endif

        // Random traffic on both instances
        for (int n = 0; n < 60; n++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            has_known = (d == 0) ? (known_q0.size() > 0) : (known_q1.size() > 0);
            if (op == 2 && has_known) begin
                if (d == 0) idx = known_q0[$urandom_range(0, known_q0.size() - 1)];
                else        idx = known_q1[$urandom_range(0, known_q1.size() - 1)];
                a = $urandom_range(0, 3) * DEPTH * 4 + idx * 4 + $urandom_range(0, 3);
                access(d, 1'b1, 1'b0, a, $urandom);
            end else if (op == 3) begin
                access(d, 1'b1, 1'b1, $urandom, $urandom);
            end else begin
                access(d, 1'b0, 1'b1, $urandom, $urandom);
            end
            repeat ($urandom_range(0, 2)) idle_cycle(d);
            drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        idle_cycle(0);
        idle_cycle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
